// File: rtl/cpu_decode_if.sv
// Fetch-to-execute handshake bundle for the decode stage: instruction/PC in,
// decoded fields out. Both sides use plain valid/ready.
interface cpu_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_class;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_class, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_class, out_illegal
  );
endinterface

// File: rtl/cpu_decode_stage.sv
// RISC-V decode stage: combinational decode of the incoming instruction into a
// two-entry (head + skid) registered buffer; outputs come straight from the head.
module cpu_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0,
  parameter bit SUPPORT_F = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  cpu_decode_if.slave  bus,
  output logic [1:0]   dbg_state_o
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready on
  // that side; flush and reset override both accept and drain.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HEAD  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam logic [3:0] C_OP_IMM  = 4'd0;
  localparam logic [3:0] C_OP      = 4'd1;
  localparam logic [3:0] C_LUI     = 4'd2;
  localparam logic [3:0] C_AUIPC   = 4'd3;
  localparam logic [3:0] C_BRANCH  = 4'd4;
  localparam logic [3:0] C_JAL     = 4'd5;
  localparam logic [3:0] C_JALR    = 4'd6;
  localparam logic [3:0] C_LOAD    = 4'd7;
  localparam logic [3:0] C_STORE   = 4'd8;
  localparam logic [3:0] C_SYSTEM  = 4'd9;
  localparam logic [3:0] C_FENCE   = 4'd10;
  localparam logic [3:0] C_MULDIV  = 4'd11;
  localparam logic [3:0] C_FPU     = 4'd12;
  localparam logic [3:0] C_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     head_q, head_d, skid_q, skid_d, dec;
  logic [31:0] ins;
  logic       is_word, is_shift, shift_legal, accept, drain, in_ready, out_valid;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins   = bus.in_instr;
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = ins[6:0];
    dec.rd      = ins[11:7];
    dec.funct3  = ins[14:12];
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.funct7  = ins[31:25];
    dec.cls     = C_ILLEGAL;
    is_word     = (ins[6:0] == 7'b0011011) || (ins[6:0] == 7'b0111011);
    is_shift    = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    shift_legal = 1'b0;
    case (ins[6:0])
      7'b0000011: begin dec.cls = C_LOAD;   dec.imm = imm_i; end
      7'b0001111: begin dec.cls = C_FENCE;  dec.imm = imm_i; end
      7'b0010111: begin dec.cls = C_AUIPC;  dec.imm = imm_u; end
      7'b0110111: begin dec.cls = C_LUI;    dec.imm = imm_u; end
      7'b0100011: begin dec.cls = C_STORE;  dec.imm = imm_s; end
      7'b1100011: begin dec.cls = C_BRANCH; dec.imm = imm_b; end
      7'b1100111: begin dec.cls = C_JALR;   dec.imm = imm_i; end
      7'b1101111: begin dec.cls = C_JAL;    dec.imm = imm_j; end
      7'b1110011: begin dec.cls = C_SYSTEM; dec.imm = imm_i; end
      7'b1010011: dec.cls = SUPPORT_F ? C_FPU : C_ILLEGAL;
      7'b0010011, 7'b0011011: begin
        if (!(is_word && XLEN == 32)) begin
          dec.cls = C_OP_IMM;
          dec.imm = imm_i;
          if (is_shift) begin
            // RV64 non-word shifts carry a 6-bit shamt, leaving a funct6 check
            if (XLEN == 64 && !is_word) begin
              dec.imm     = XLEN'(ins[25:20]);
              shift_legal = (ins[31:26] == 6'b000000) ||
                            (ins[14:12] == 3'b101 && ins[31:26] == 6'b010000);
            end else begin
              dec.imm     = XLEN'(ins[24:20]);
              shift_legal = (ins[31:25] == 7'b0000000) ||
                            (ins[14:12] == 3'b101 && ins[31:25] == 7'b0100000);
            end
            if (!shift_legal) dec.cls = C_ILLEGAL;
          end
        end
      end
      7'b0110011, 7'b0111011: begin
        if (!(is_word && XLEN == 32)) begin
          if (ins[31:25] == 7'b0000001) dec.cls = SUPPORT_M ? C_MULDIV : C_ILLEGAL;
          else                          dec.cls = C_OP;
        end
      end
      default: dec.cls = C_ILLEGAL;
    endcase
  end

  assign in_ready  = (state_q != S_FULL) && !reset;
  assign out_valid = (state_q != S_EMPTY) && !reset;
  assign accept    = bus.in_valid && in_ready;
  assign drain     = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin head_d = dec; state_d = S_HEAD; end
        S_HEAD: begin
          if (accept && drain)   head_d = dec;
          else if (accept)       begin skid_d = dec; state_d = S_FULL; end
          else if (drain)        state_d = S_EMPTY;
        end
        S_FULL: if (drain) begin head_d = skid_q; state_d = S_HEAD; end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = head_q.pc;
  assign bus.out_opcode  = head_q.opcode;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_funct3  = head_q.funct3;
  assign bus.out_rs1     = head_q.rs1;
  assign bus.out_rs2     = head_q.rs2;
  assign bus.out_funct7  = head_q.funct7;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_class   = head_q.cls;
  assign bus.out_illegal = (head_q.cls == C_ILLEGAL);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Bench for cpu_decode_stage: an RV32 instance (no M/F) checked through an
// expected-entry queue, plus an RV64 instance with M and F for decode checks.
module tb_cpu_decode_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  logic [1:0] dbg32, dbg64;
  always #5 clk = ~clk;

  cpu_decode_if #(.XLEN(32)) bus32();
  cpu_decode_if #(.XLEN(64)) bus64();

  cpu_decode_stage #(.XLEN(32), .SUPPORT_M(1'b0), .SUPPORT_F(1'b0)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus32), .dbg_state_o(dbg32)
  );
  cpu_decode_stage #(.XLEN(64), .SUPPORT_M(1'b1), .SUPPORT_F(1'b1)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush64), .bus(bus64), .dbg_state_o(dbg64)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        chk_imm;
  } exp_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int n_out = 0;
  logic [3:0]  cur_cls;
  logic [31:0] cur_imm;
  logic        cur_chk;

  logic [31:0] tbl_instr [0:16] = '{
    32'hFFF00093, 32'h123452B7, 32'hFFFFF517, 32'hFE208EE3, 32'h001000EF,
    32'h00008067, 32'h00812183, 32'hFE512C23, 32'h00000073, 32'h0FF0000F,
    32'h002081B3, 32'h02208033, 32'h00000000, 32'h43F0D093, 32'h00309093,
    32'h0010809B, 32'h00000053};
  logic [3:0] tbl_cls [0:16] = '{
    4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
    4'd1, 4'd15, 4'd15, 4'd15, 4'd0, 4'd15, 4'd15};
  logic [31:0] tbl_imm [0:16] = '{
    32'hFFFFFFFF, 32'h12345000, 32'hFFFFF000, 32'hFFFFFFFC, 32'h00000800,
    32'h0, 32'h8, 32'hFFFFFFF8, 32'h0, 32'h000000FF,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h0, 32'h0};

  logic [31:0] t64_instr [0:5] = '{
    32'h43F0D093, 32'h02208033, 32'h0010809B, 32'h00000053, 32'h800002B7, 32'hFE512C23};
  logic [3:0] t64_cls [0:5] = '{4'd0, 4'd11, 4'd0, 4'd12, 4'd2, 4'd8};
  logic [63:0] t64_imm [0:5] = '{
    64'd63, 64'd0, 64'd1, 64'd0, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFF8};

  task automatic drive_in(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [3:0] cls, input logic [31:0] imm);
    bus32.in_valid = 1'b1;
    bus32.in_instr = instr;
    bus32.in_pc    = pc;
    cur_cls = cls;
    cur_imm = imm;
    cur_chk = (cls != 4'd15);
  endtask

  // Scores the transfers that will happen at the coming edge, then advances.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (!reset && !flush && bus32.out_valid && bus32.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL sb_unexpected: output pc %h emitted, none expected", bus32.out_pc);
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (bus32.out_pc !== e.pc) begin
          tests_failed++;
          $display("FAIL sb_pc: got %h expected %h", bus32.out_pc, e.pc);
        end
        tests_run++;
        if (bus32.out_class !== e.cls || bus32.out_illegal !== (e.cls == 4'd15)) begin
          tests_failed++;
          $display("FAIL sb_class pc %h: got class %0d illegal %b expected class %0d",
                   e.pc, bus32.out_class, bus32.out_illegal, e.cls);
        end
        tests_run++;
        if ({bus32.out_opcode, bus32.out_rd, bus32.out_funct3, bus32.out_rs1,
             bus32.out_rs2, bus32.out_funct7} !==
            {e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
             e.instr[24:20], e.instr[31:25]}) begin
          tests_failed++;
          $display("FAIL sb_fields pc %h: opc %b rd %0d f3 %0d rs1 %0d rs2 %0d f7 %b for instr %h",
                   e.pc, bus32.out_opcode, bus32.out_rd, bus32.out_funct3, bus32.out_rs1,
                   bus32.out_rs2, bus32.out_funct7, e.instr);
        end
        if (e.chk_imm) begin
          tests_run++;
          if (bus32.out_imm !== e.imm) begin
            tests_failed++;
            $display("FAIL sb_imm pc %h: got %h expected %h", e.pc, bus32.out_imm, e.imm);
          end
        end
      end
    end
    if (!reset && !flush && bus32.in_valid && bus32.in_ready) begin
      exp_q.push_back({bus32.in_instr, bus32.in_pc, cur_cls, cur_imm, cur_chk});
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(acc);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit acc;
    tick(acc);
    tick(acc);
    tests_run++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: out_valid %b in_ready %b in_ready64 %b, need 0 0 0",
               bus32.out_valid, bus32.in_ready, bus64.in_ready);
    end
    tests_run++;
    if (bus32.out_class !== 4'd0 || bus32.out_illegal !== 1'b0 || bus32.out_imm !== 32'd0 ||
        bus32.out_pc !== 32'd0 || bus32.out_rd !== 5'd0 || bus32.out_opcode !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_payload: class %0d illegal %b imm %h pc %h, need all zero",
               bus32.out_class, bus32.out_illegal, bus32.out_imm, bus32.out_pc);
    end
    reset = 1'b0;
    tick(acc);
    tests_run++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready %b out_valid %b, need 1 0",
               bus32.in_ready, bus32.out_valid);
    end
  endtask

  task automatic test_addi();
    bit acc;
    bus32.out_ready = 1'b1;
    drive_in(32'hFFF00093, 32'h100, 4'd0, 32'hFFFFFFFF);
    tick(acc);
    bus32.in_valid = 1'b0;
    tests_run++;
    if (acc !== 1'b1 || bus32.out_valid !== 1'b1 || bus32.out_rd !== 5'd1 ||
        bus32.out_class !== 4'd0 || bus32.out_imm !== 32'hFFFFFFFF || bus32.out_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL addi: acc %b valid %b rd %0d class %0d imm %h pc %h, need 1 1 1 0 ffffffff 00000100",
               acc, bus32.out_valid, bus32.out_rd, bus32.out_class, bus32.out_imm, bus32.out_pc);
    end
    drain();
  endtask

  task automatic test_decode_table();
    bit acc;
    for (int i = 0; i < 17; i++) begin
      drive_in(tbl_instr[i], 32'h1000 + 32'(i * 4), tbl_cls[i], tbl_imm[i]);
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        bus32.out_ready = 1'($urandom_range(0, 1));
        tick(acc);
      end
      if (!acc) begin
        tests_run++; tests_failed++;
        $display("FAIL table_accept_timeout: entry %0d never accepted", i);
      end
      bus32.in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) tick(acc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n0;
    n0 = n_out;
    bus32.out_ready = 1'b0;
    drive_in(32'h00812183, 32'h200, 4'd7, 32'h8);
    tick(acc);
    drive_in(32'hFE512C23, 32'h204, 4'd8, 32'hFFFFFFF8);
    tick(acc);
    tests_run++;
    if (bus32.in_ready !== 1'b0 || dbg32 !== 2'd2) begin
      tests_failed++;
      $display("FAIL b2b_full: in_ready %b state %0d, need 0 2", bus32.in_ready, dbg32);
    end
    drive_in(32'h002081B3, 32'h208, 4'd1, 32'h0);
    tick(acc);
    tick(acc);
    tests_run++;
    if (acc !== 1'b0 || bus32.out_pc !== 32'h200 || bus32.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_hold: acc %b out_pc %h valid %b, need 0 00000200 1",
               acc, bus32.out_pc, bus32.out_valid);
    end
    bus32.out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) tick(acc);
    bus32.in_valid = 1'b0;
    drain();
    tick(acc);
    tests_run++;
    if (n_out - n0 !== 3 || bus32.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d outputs, valid %b, need 3 0", n_out - n0, bus32.out_valid);
    end
  endtask

  task automatic test_flush();
    bit acc;
    int n0;
    bus32.out_ready = 1'b0;
    drive_in(32'h00000073, 32'h300, 4'd9, 32'h0);
    tick(acc);
    drive_in(32'h0FF0000F, 32'h304, 4'd10, 32'hFF);
    tick(acc);
    tests_run++;
    if (dbg32 !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_prefill: state %0d, need 2", dbg32);
    end
    drive_in(32'h002081B3, 32'h308, 4'd1, 32'h0);
    bus32.out_ready = 1'b1;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    tests_run++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: out_valid %b in_ready %b, need 0 1",
               bus32.out_valid, bus32.in_ready);
    end
    exp_q.delete();
    n0 = n_out;
    for (int k = 0; k < 5; k++) tick(acc);
    tests_run++;
    if (n_out != n0) begin
      tests_failed++;
      $display("FAIL flush_leak: %0d outputs after flush, need 0", n_out - n0);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int n0;
    bus32.out_ready = 1'b0;
    drive_in(32'h00309093, 32'h400, 4'd0, 32'h3);
    tick(acc);
    bus32.in_valid = 1'b0;
    tests_run++;
    if (bus32.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_load: out_valid %b, need 1", bus32.out_valid);
    end
    reset = 1'b1;
    tick(acc);
    tests_run++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_in_reset: out_valid %b in_ready %b, need 0 0",
               bus32.out_valid, bus32.in_ready);
    end
    exp_q.delete();
    reset = 1'b0;
    n0 = n_out;
    tick(acc);
    tests_run++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_release: in_ready %b out_valid %b, need 1 0",
               bus32.in_ready, bus32.out_valid);
    end
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick(acc);
    tests_run++;
    if (n_out != n0) begin
      tests_failed++;
      $display("FAIL rmid_leak: %0d stale outputs, need 0", n_out - n0);
    end
  endtask

  task automatic test_rv64();
    bit acc;
    logic [63:0] pc;
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 64'h1_0000_0000 + 64'(i * 4);
      bus64.in_valid = 1'b1;
      bus64.in_instr = t64_instr[i];
      bus64.in_pc    = pc;
      tick(acc);
      bus64.in_valid = 1'b0;
      tests_run++;
      if (bus64.out_valid !== 1'b1 || bus64.out_class !== t64_cls[i] ||
          bus64.out_imm !== t64_imm[i] || bus64.out_pc !== pc ||
          bus64.out_illegal !== 1'b0) begin
        tests_failed++;
        $display("FAIL rv64_%0d: valid %b class %0d imm %h pc %h illegal %b, need 1 %0d %h %h 0",
                 i, bus64.out_valid, bus64.out_class, bus64.out_imm, bus64.out_pc,
                 bus64.out_illegal, t64_cls[i], t64_imm[i], pc);
      end
    end
    tick(acc);
    tests_run++;
    if (bus64.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rv64_drain: out_valid %b, need 0", bus64.out_valid);
    end
  endtask

  initial begin
    bus32.in_valid  = 1'b0;
    bus32.in_instr  = '0;
    bus32.in_pc     = '0;
    bus32.out_ready = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_instr  = '0;
    bus64.in_pc     = '0;
    bus64.out_ready = 1'b0;
    cur_cls = '0;
    cur_imm = '0;
    cur_chk = 1'b0;
    test_reset();
    test_addi();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_rv64();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_decode_stage.md
CPU_DECODE_STAGE -- requirements
Module: cpu_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SUPPORT_M, 0, 1 = decode M-extension OP/OP-32 encodings as MULDIV.
REQ-003 SHALL have parameter SUPPORT_F, 0, 1 = decode opcode 1010011 as FPU.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all buffered instructions.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input XLEN: fetch-side handshake and payload.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-009 SHALL have outputs out_pc XLEN, out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5, out_funct7 7, out_imm XLEN: decoded fields of the head entry.
REQ-010 SHALL have output out_class 4, which encodes: 0 OP_IMM, 1 OP, 2 LUI, 3 AUIPC, 4 BRANCH, 5 JAL, 6 JALR, 7 LOAD, 8 STORE, 9 SYSTEM, 10 FENCE, 11 MULDIV, 12 FPU, 15 ILLEGAL.
REQ-011 SHALL have output out_illegal 1, asserted iff out_class == 15.

Function
REQ-012 SHALL decode combinationally from in_instr and register the results; no decode logic on the output path.
REQ-013 SHALL hold two entries: head (drives outputs) and skid; FIFO order preserved.
REQ-014 SHALL accept on in_valid&in_ready; SHALL drain head on out_valid&out_ready; skid promotes to head on the same edge the head drains.
REQ-015 SHALL drive in_ready = !skid_valid & !reset, a registered signal with no combinational path from out_ready.
REQ-016 SHALL give 1-cycle latency: instruction accepted at edge N into empty stage gives out_valid=1 after edge N.
REQ-017 SHALL, with head full and draining while input arrives, load the new entry into the head and leave skid empty (no bubble).
REQ-018 SHALL keep out_* payload stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on flush=1, clear both entries at the edge, ignore same-cycle in_valid, and drive out_valid=0 and in_ready=1 the next cycle; flush SHALL override accept and drain.
REQ-020 SHALL build immediates sign-extended to XLEN:
- I for LOAD/OP-IMM/JALR/SYSTEM/FENCE
- S for STORE
- B for BRANCH (bit0=0)
- U for LUI/AUIPC (bits 11:0=0, sign-extended from bit 31)
- J for JAL (bit0=0)
- 0 otherwise
REQ-021 SHALL zero-extend shift amounts for OP-IMM shifts: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-022 SHALL classify as ILLEGAL:
- instr[1:0] != 11 or unlisted opcode
- OP-IMM-32/OP-32 when XLEN=32
- SLLI/SRLI/SRAI with bad funct7 (RV32) or funct6 (RV64) high bits, including shamt[5]=1 on RV32
- funct7=0000001 on OP/OP-32 when SUPPORT_M=0
- FPU opcode when SUPPORT_F=0
REQ-023 SHALL classify OP-IMM-32 as OP_IMM and OP-32 as OP (or MULDIV) when XLEN=64.
REQ-024 SHALL pass out_rd/rs1/rs2/funct3/funct7/opcode as raw bit slices regardless of class.

Reset
REQ-025 SHALL, while reset=1, clear head_valid and skid_valid, and drive out_valid=0 and in_ready=0.
REQ-026 SHALL reset every payload output to 0, including out_class=0 and out_illegal=0.
REQ-027 SHALL drive in_ready=1 the first cycle after reset deasserts; reset mid-transfer drops buffered entries with no output.

Verification
REQ-028 ADDI 0xFFF00093, pc 0x100, out_ready=1 -> next cycle out_valid=1, rd=1, class 0, out_imm=0xFFFFFFFF, out_pc=0x100.
REQ-029 out_ready=0 with 3 back-to-back instructions A,B,C -> A,B accepted, in_ready=0 after B, C held; release out_ready -> A,B,C emitted in order, no duplicates or drops.
REQ-030 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed instruction never emitted.
REQ-031 in_instr 0x00000000 -> class 15, out_illegal=1; MUL 0x02208033 with SUPPORT_M=0 -> class 15; with SUPPORT_M=1 -> class 11.
REQ-032 SRAI 0x43F0D093 with XLEN=64 -> class 0, out_imm=63; same instruction with XLEN=32 -> class 15.
REQ-033 reset pulsed with head full and out_ready=0 -> out_valid=0 next cycle, in_ready=1 one cycle after reset falls, old entry never emitted.
